// File: rtl/checksum_verifier.sv
// rtl/checksum_verifier.sv - row/column checksum verification of a checksum-augmented matrix
//
// Purpose:
//   Accepts one checksum-augmented row per handshake. Each row holds COLS data
//   elements and one row checksum. The frame ends with a checksum row. Every row
//   sum is checked as the row arrives. Column sums are accumulated over the data
//   rows and compared against the checksum row once the frame is complete.
//
// Ports:
//   clk                  clock
//   rst                  synchronous, active-high reset
//   verify_enable        frame enable level: high in IDLE starts a frame, low in ACCUM aborts it
//   row_valid            row_data carries a row this cycle
//   row_data             element c at [c*DATA_W +: DATA_W]; element COLS is the row checksum
//   row_ready            block accepts a row this cycle
//   error                any row or column mismatch in the last completed frame
//   column_indicator     bit c set when the column c sum mismatches its checksum-row entry
//   row_error_flag       at least one row-sum mismatch in the current/last frame
//   error_row            index of the first mismatching row (0 if none)
//   column_verify_ready  one-cycle pulse: error/column_indicator are valid
module checksum_verifier #(
  parameter int DATA_W = 32,
  parameter int COLS   = 32,
  parameter int ROWS   = 32,
  parameter int IDX_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       verify_enable,
  input  logic                       row_valid,
  input  logic [(COLS+1)*DATA_W-1:0] row_data,
  output logic                       row_ready,
  output logic                       error,
  output logic [COLS:0]              column_indicator,
  output logic                       row_error_flag,
  output logic [IDX_W-1:0]           error_row,
  output logic                       column_verify_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS);

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] col_acc [0:COLS];
  logic [DATA_W-1:0] cs_reg  [0:COLS];
  logic [IDX_W-1:0]  row_cnt;
  logic [DATA_W-1:0] row_sum;
  logic              row_mismatch;
  logic              accept;
  logic              last_row;
  logic [COLS:0]     col_mismatch;

  // Sum of the data elements of the incoming row, wrapping mod 2^DATA_W.
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < COLS; c++) begin
      row_sum = row_sum + row_data[c*DATA_W +: DATA_W];
    end
  end

  assign row_mismatch = (row_sum != row_data[COLS*DATA_W +: DATA_W]);
  assign last_row     = (row_cnt == LAST_ROW);
  // A row presented on the abort edge (verify_enable low) is discarded.
  assign accept       = row_ready & row_valid & verify_enable;

  always_comb begin
    col_mismatch = '0;
    for (int c = 0; c <= COLS; c++) begin
      col_mismatch[c] = (col_acc[c] != cs_reg[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    row_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (verify_enable) state_next = ACCUM;
      end
      ACCUM: begin
        row_ready = 1'b1;
        if (!verify_enable) begin
          state_next = IDLE;
        end else if (row_valid && last_row) begin
          state_next = COMPARE;
        end
      end
      COMPARE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt             <= '0;
      error               <= 1'b0;
      column_indicator    <= '0;
      row_error_flag      <= 1'b0;
      error_row           <= '0;
      column_verify_ready <= 1'b0;
      for (int c = 0; c <= COLS; c++) begin
        col_acc[c] <= '0;
        cs_reg[c]  <= '0;
      end
    end else begin
      column_verify_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Previous results hold until a new frame is started.
          if (verify_enable) begin
            row_cnt          <= '0;
            error            <= 1'b0;
            column_indicator <= '0;
            row_error_flag   <= 1'b0;
            error_row        <= '0;
            for (int c = 0; c <= COLS; c++) begin
              col_acc[c] <= '0;
              cs_reg[c]  <= '0;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            // The checksum row is latched for the final compare, not accumulated.
            for (int c = 0; c <= COLS; c++) begin
              if (last_row) begin
                cs_reg[c] <= row_data[c*DATA_W +: DATA_W];
              end else begin
                col_acc[c] <= col_acc[c] + row_data[c*DATA_W +: DATA_W];
              end
            end
            if (row_mismatch) begin
              row_error_flag <= 1'b1;
              if (!row_error_flag) error_row <= row_cnt;
            end
            row_cnt <= row_cnt + IDX_W'(1);
          end
        end
        COMPARE: begin
          column_indicator    <= col_mismatch;
          error               <= (|col_mismatch) | row_error_flag;
          column_verify_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_checksum_verifier.sv
// tb/tb_checksum_verifier.sv - self-checking bench for checksum_verifier
module tb_checksum_verifier;

  localparam int DATA_W = 32;
  localparam int COLS   = 32;
  localparam int ROWS   = 32;
  localparam int IDX_W  = 6;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       verify_enable;
  logic                       row_valid;
  logic [(COLS+1)*DATA_W-1:0] row_data;
  logic                       row_ready;
  logic                       error;
  logic [COLS:0]              column_indicator;
  logic                       row_error_flag;
  logic [IDX_W-1:0]           error_row;
  logic                       column_verify_ready;

  checksum_verifier #(
    .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .verify_enable       (verify_enable),
    .row_valid           (row_valid),
    .row_data            (row_data),
    .row_ready           (row_ready),
    .error               (error),
    .column_indicator    (column_indicator),
    .row_error_flag      (row_error_flag),
    .error_row           (error_row),
    .column_verify_ready (column_verify_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int exp_ready_cyc = -1;
  int last_acc_cyc = 0;

  // Frame contents: rows 0..ROWS-1 are data rows, row ROWS is the checksum row.
  logic [DATA_W-1:0] frame [0:ROWS][0:COLS];

  logic [COLS:0]    exp_ind;
  logic             exp_ref;
  logic             exp_err;
  logic [IDX_W-1:0] exp_erow;

  logic [COLS:0]    cap_ind;
  logic             cap_err;
  logic             cap_ref;
  logic [IDX_W-1:0] cap_erow;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_clean(input logic [DATA_W-1:0] v);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) frame[r][c] = v;
      frame[r][COLS] = v * DATA_W'(COLS);
    end
    for (int c = 0; c < COLS; c++) frame[ROWS][c] = v * DATA_W'(ROWS);
    frame[ROWS][COLS] = v * DATA_W'(COLS) * DATA_W'(ROWS);
  endtask

  // Whole-frame reference: column sums vs checksum row, row sums vs row checksum.
  task automatic compute_model();
    logic [DATA_W-1:0] s;
    exp_ind  = '0;
    exp_ref  = 1'b0;
    exp_erow = '0;
    for (int c = 0; c <= COLS; c++) begin
      s = '0;
      for (int r = 0; r < ROWS; r++) s = s + frame[r][c];
      exp_ind[c] = (s != frame[ROWS][c]);
    end
    for (int r = 0; r <= ROWS; r++) begin
      s = '0;
      for (int c = 0; c < COLS; c++) s = s + frame[r][c];
      if (s != frame[r][COLS]) begin
        if (!exp_ref) exp_erow = IDX_W'(r);
        exp_ref = 1'b1;
      end
    end
    exp_err = (|exp_ind) | exp_ref;
  endtask

  // Called and returns at a negedge; the row is taken at the posedge in between.
  task automatic send_row(input int r, input int gap);
    logic [(COLS+1)*DATA_W-1:0] pk;
    int budget;
    for (int c = 0; c <= COLS; c++) pk[c*DATA_W +: DATA_W] = frame[r][c];
    if (gap > 0) begin
      row_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    row_valid = 1'b1;
    row_data  = pk;
    budget    = 0;
    while (!row_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!row_ready) begin
      tests++;
      fails++;
      $display("FAIL row_ready_timeout row %0d: got 0, expected 1", r);
    end
    @(posedge clk);
    @(negedge clk);
    last_acc_cyc = cyc;
  endtask

  task automatic run_frame(input int gap);
    pulses = 0;
    compute_model();
    verify_enable = 1'b1;
    for (int r = 0; r <= ROWS; r++) send_row(r, gap);
    // Results pulse in the second cycle after the checksum-row edge.
    exp_ready_cyc = last_acc_cyc + 1;
    row_valid     = 1'b0;
    verify_enable = 1'b0;
    repeat (4) @(negedge clk);
    check("pulse_count", pulses, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_pulse", column_verify_ready, (cyc == exp_ready_cyc));
      if (column_verify_ready) begin
        pulses++;
        cap_ind  = column_indicator;
        cap_err  = error;
        cap_ref  = row_error_flag;
        cap_erow = error_row;
        check("model_error", error, exp_err);
        check("model_indicator", column_indicator, exp_ind);
        check("model_row_error_flag", row_error_flag, exp_ref);
        check("model_error_row", error_row, exp_erow);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    verify_enable = 1'b0;
    row_valid     = 1'b0;
    row_data      = '0;
    repeat (2) @(negedge clk);
    check("rst_row_ready", row_ready, 0);
    check("rst_error", error, 0);
    check("rst_indicator", column_indicator, 0);
    check("rst_row_error_flag", row_error_flag, 0);
    check("rst_error_row", error_row, 0);
    check("rst_verify_ready", column_verify_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a frame that already saw a bad row.
    build_clean(32'd1);
    frame[2][0] = 32'd5;
    verify_enable = 1'b1;
    for (int r = 0; r < 10; r++) send_row(r, 0);
    row_valid = 1'b0;
    check("midframe_row_error_flag", row_error_flag, 1);
    rst = 1'b1;
    verify_enable = 1'b0;
    @(negedge clk);
    check("midrst_row_ready", row_ready, 0);
    check("midrst_error", error, 0);
    check("midrst_indicator", column_indicator, 0);
    check("midrst_row_error_flag", row_error_flag, 0);
    check("midrst_error_row", error_row, 0);
    check("midrst_verify_ready", column_verify_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_row_ready", row_ready, 0);

    build_clean(32'd1);
    run_frame(0);
    check("after_rst_clean_error", cap_err, 0);
    check("after_rst_clean_indicator", cap_ind, 0);

    // Clean frame with 3-cycle gaps between rows.
    build_clean(32'd1);
    run_frame(3);
    check("gap_clean_error", cap_err, 0);
    check("gap_clean_indicator", cap_ind, 0);
    check("gap_clean_row_error_flag", cap_ref, 0);

    // Single data fault at (5,7).
    build_clean(32'd1);
    frame[5][7] = 32'd2;
    run_frame(0);
    check("model_pin_single_ind", exp_ind, 33'h0_0000_0080);
    check("single_error", cap_err, 1);
    check("single_indicator", cap_ind, 33'h0_0000_0080);
    check("single_row_error_flag", cap_ref, 1);
    check("single_error_row", cap_erow, 5);
    check("single_hold_error", error, 1);
    check("single_hold_indicator", column_indicator, 33'h0_0000_0080);

    // Fault in the row-checksum column.
    build_clean(32'd1);
    frame[3][COLS] = 32'd33;
    run_frame(0);
    check("model_pin_cscol_ind", exp_ind, 33'h1_0000_0000);
    check("cscol_error", cap_err, 1);
    check("cscol_indicator", cap_ind, 33'h1_0000_0000);
    check("cscol_row_error_flag", cap_ref, 1);
    check("cscol_error_row", cap_erow, 3);

    // Fault inside the checksum row itself: error_row equals ROWS.
    build_clean(32'd1);
    frame[ROWS][4] = 32'd33;
    run_frame(0);
    check("csrow_indicator", cap_ind, 33'h0_0000_0010);
    check("csrow_error_row", cap_erow, 32);
    check("csrow_error", cap_err, 1);

    // Two faulty rows: the first one is reported.
    build_clean(32'd1);
    frame[4][0] = 32'd0;
    frame[9][1] = 32'd3;
    run_frame(0);
    check("two_error_row", cap_erow, 4);
    check("two_indicator", cap_ind, 33'h0_0000_0003);

    // Wrap-around arithmetic.
    build_clean(32'hFFFF_FFFF);
    check("wrap_row_checksum", frame[0][COLS], 32'hFFFF_FFE0);
    check("wrap_corner", frame[ROWS][COLS], 32'hFFFF_FC00);
    run_frame(0);
    check("wrap_error", cap_err, 0);
    check("wrap_indicator", cap_ind, 0);

    // Abort after 10 rows, then an immediate clean frame.
    build_clean(32'd1);
    pulses = 0;
    verify_enable = 1'b1;
    for (int r = 0; r < 10; r++) send_row(r, 0);
    verify_enable = 1'b0;
    @(negedge clk);
    row_valid = 1'b0;
    check("abort_row_ready", row_ready, 0);
    check("abort_error", error, 0);
    check("abort_indicator", column_indicator, 0);
    repeat (3) @(negedge clk);
    check("abort_no_pulse", pulses, 0);
    run_frame(0);
    check("restart_error", cap_err, 0);
    check("restart_indicator", cap_ind, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
